// File: rtl/uart_parity_engine_if.sv
// uart_parity_engine_if: groups the frame control, serial bit, handshake and error signals of
// uart_parity_engine.
//   slave  modport: the parity engine (takes frame/bit/ack/clear, returns parity and status)
//   master modport: the UART bit path driving the engine
// Optional macro UART_PARITY_ERR_CNT_EN adds the err_cnt signal.
`timescale 1ns/1ps

interface uart_parity_engine_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ERR_CNT_W = 8
);
    localparam int unsigned LEN_W = $clog2(DATA_BITS + 1);

    logic             frame_start;
    logic [2:0]       parity_mode;
    logic             dir_rx;
    logic [LEN_W-1:0] data_len;
    logic             bit_valid;
    logic             bit_in;
    logic             parity_ack;
    logic             err_clr;
    logic             parity_bit;
    logic             parity_valid;
    logic             parity_err;
    logic             sticky_err;
    logic             frame_done;
    logic             busy;
`ifdef UART_PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;
`endif

    if (DATA_BITS < 1 || ERR_CNT_W < 1) begin : g_bad_params
        $error("uart_parity_engine_if: DATA_BITS and ERR_CNT_W must be >= 1");
    end

    modport master (
        output frame_start, parity_mode, dir_rx, data_len, bit_valid, bit_in, parity_ack,
               err_clr,
        input  parity_bit, parity_valid, parity_err, sticky_err, frame_done, busy
`ifdef UART_PARITY_ERR_CNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  frame_start, parity_mode, dir_rx, data_len, bit_valid, bit_in, parity_ack,
               err_clr,
        output parity_bit, parity_valid, parity_err, sticky_err, frame_done, busy
`ifdef UART_PARITY_ERR_CNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/uart_parity_engine.sv
// uart_parity_engine: serial parity engine for the UART TX/RX bit paths. Accumulates parity one
// bit at a time (LSB first) over a runtime-length frame, in none/even/odd/mark/space mode.
//   TX: presents parity_bit with parity_valid, held until parity_ack.
//   RX: compares the received parity bit, pulses parity_err and sets sticky_err.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         uart_parity_engine_if.slave (frame control, serial bits, handshake, status)
// Optional macro UART_PARITY_ERR_CNT_EN: adds a saturating parity error counter (bus.err_cnt).
// All outputs come from registers; no combinational input-to-output paths.
`timescale 1ns/1ps

module uart_parity_engine #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_parity_engine_if.slave bus
);
    localparam int unsigned      LEN_W   = $clog2(DATA_BITS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_BITS);

    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;
    typedef enum logic [2:0] {
        ModeNone  = 3'd0,
        ModeEven  = 3'd1,
        ModeOdd   = 3'd2,
        ModeMark  = 3'd3,
        ModeSpace = 3'd4
    } mode_e;

    if (DATA_BITS < 1 || ERR_CNT_W < 1) begin : g_bad_params
        $error("uart_parity_engine: DATA_BITS and ERR_CNT_W must be >= 1");
    end

    // Reserved encodings collapse to none so the FSM only ever sees five modes.
    function automatic mode_e decode_mode(input logic [2:0] m);
        mode_e res;
        case (m)
            3'd1:    res = ModeEven;
            3'd2:    res = ModeOdd;
            3'd3:    res = ModeMark;
            3'd4:    res = ModeSpace;
            default: res = ModeNone;
        endcase
        return res;
    endfunction

    function automatic logic parity_of(input mode_e m, input logic acc);
        logic res;
        case (m)
            ModeEven: res = acc;
            ModeOdd:  res = ~acc;
            ModeMark: res = 1'b1;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic             dir_rx_q, dir_rx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] cnt_inc;
    logic             acc_q, acc_d;
    logic             acc_nxt;
    logic             par_q, par_d;      // expected parity, valid in StParity
    logic             par_nxt;
    logic             parity_bit_q, parity_bit_d;
    logic             parity_valid_q, parity_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_done_q, frame_done_d;
    logic             sticky_q, sticky_d;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        dir_rx_d       = dir_rx_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        par_d          = par_q;
        parity_bit_d   = parity_bit_q;
        parity_valid_d = parity_valid_q;
        parity_err_d   = 1'b0;
        frame_done_d   = 1'b0;
        cnt_inc        = cnt_q + LEN_W'(1);
        acc_nxt        = acc_q ^ bus.bit_in;
        par_nxt        = parity_of(mode_q, acc_nxt);

        if (bus.frame_start) begin
            // Restart from any state; a coincident bit_valid is dropped.
            state_d        = StData;
            mode_d         = decode_mode(bus.parity_mode);
            dir_rx_d       = bus.dir_rx;
            len_d          = (bus.data_len == '0 || bus.data_len > MAX_LEN) ? MAX_LEN
                                                                             : bus.data_len;
            cnt_d          = '0;
            acc_d          = 1'b0;
            parity_bit_d   = 1'b0;
            parity_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StData: begin
                    if (bus.bit_valid) begin
                        acc_d = acc_nxt;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            if (mode_q == ModeNone) begin
                                frame_done_d = 1'b1;
                                state_d      = StIdle;
                            end else begin
                                state_d = StParity;
                                par_d   = par_nxt;
                                if (!dir_rx_q) begin
                                    parity_bit_d   = par_nxt;
                                    parity_valid_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                StParity: begin
                    if (!dir_rx_q) begin
                        if (bus.parity_ack) begin
                            parity_bit_d   = 1'b0;
                            parity_valid_d = 1'b0;
                            frame_done_d   = 1'b1;
                            state_d        = StIdle;
                        end
                    end else if (bus.bit_valid) begin
                        parity_err_d = bus.bit_in ^ par_q;
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Set has priority over clear.
        sticky_d = parity_err_d | (sticky_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            mode_q         <= ModeNone;
            dir_rx_q       <= 1'b0;
            len_q          <= '0;
            cnt_q          <= '0;
            acc_q          <= 1'b0;
            par_q          <= 1'b0;
            parity_bit_q   <= 1'b0;
            parity_valid_q <= 1'b0;
            parity_err_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            sticky_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            dir_rx_q       <= dir_rx_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            par_q          <= par_d;
            parity_bit_q   <= parity_bit_d;
            parity_valid_q <= parity_valid_d;
            parity_err_q   <= parity_err_d;
            frame_done_q   <= frame_done_d;
            sticky_q       <= sticky_d;
        end
    end

    assign bus.parity_bit   = parity_bit_q;
    assign bus.parity_valid = parity_valid_q;
    assign bus.parity_err   = parity_err_q;
    assign bus.sticky_err   = sticky_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = (state_q != StIdle);

`ifdef UART_PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, err_cnt_base;

    // Clear first, then count: a simultaneous clear and error leaves the count at 1.
    always_comb begin
        err_cnt_base = bus.err_clr ? '0 : err_cnt_q;
        err_cnt_d    = err_cnt_base;
        if (parity_err_d && (err_cnt_base != '1)) begin
            err_cnt_d = err_cnt_base + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Testbench for uart_parity_engine: directed frames with a scoreboard of expected per-frame
// results (parity_valid seen, parity_bit, parity_err) popped on every frame_done.
`timescale 1ns/1ps

module tb_uart_parity_engine;
    logic clk;
    logic rst_n;

    uart_parity_engine_if #(.DATA_BITS(8), .ERR_CNT_W(8)) bus ();

    uart_parity_engine #(.DATA_BITS(8), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic pv;
        logic pb;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic seen_pv  = 1'b0;
    logic seen_pb  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_pv = 1'b0;
        end else begin
            if (bus.parity_valid && !seen_pv) begin
                seen_pv = 1'b1;
                seen_pb = bus.parity_bit;
            end
            if (bus.frame_done) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_pv", 32'(seen_pv), 32'(e.pv));
                    if (e.pv) check("sb_pb", 32'(seen_pb), 32'(e.pb));
                    check("sb_err", 32'(bus.parity_err), 32'(e.err));
                end
                seen_pv = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [2:0] mode, input logic rx, input logic [3:0] len);
        bus.frame_start = 1'b1;
        bus.parity_mode = mode;
        bus.dir_rx      = rx;
        bus.data_len    = len;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        step();
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic do_ack();
        bus.parity_ack = 1'b1;
        step();
        bus.parity_ack = 1'b0;
    endtask

    function automatic logic par_model(input logic [2:0] mode, input logic [7:0] d, input int n);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < n; i++) acc ^= d[i];
        case (mode)
            3'd1:    return acc;
            3'd2:    return ~acc;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tx_frame(input logic [2:0] mode, input logic [3:0] len, input logic [7:0] d);
        int   n;
        logic none;
        logic p;
        n    = (len == 0 || len > 8) ? 8 : int'(len);
        none = (mode == 3'd0 || mode > 3'd4);
        p    = none ? 1'b0 : par_model(mode, d, n);
        sb.push_back('{pv: ~none, pb: p, err: 1'b0});
        start_frame(mode, 1'b0, len);
        send_data(d, n);
        if (!none) begin
            check("tx_pv", 32'(bus.parity_valid), 32'd1);
            check("tx_pb", 32'(bus.parity_bit), 32'(p));
            do_ack();
        end
        check("tx_done", 32'(bus.frame_done), 32'd1);
        check("tx_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic rx_frame(input logic [2:0] mode, input logic [3:0] len, input logic [7:0] d,
                            input logic rxpar, input logic clr);
        logic err;
        err = rxpar ^ par_model(mode, d, int'(len));
        sb.push_back('{pv: 1'b0, pb: 1'b0, err: err});
        start_frame(mode, 1'b1, len);
        send_data(d, int'(len));
        bus.err_clr = clr;
        send_bit(rxpar);
        bus.err_clr = 1'b0;
        check("rx_err", 32'(bus.parity_err), 32'(err));
        check("rx_done", 32'(bus.frame_done), 32'd1);
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.parity_mode = 3'd0;
        bus.dir_rx      = 1'b0;
        bus.data_len    = '0;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;
        bus.parity_ack  = 1'b0;
        bus.err_clr     = 1'b0;
        rst_n           = 1'b0;
        #1;
        check("rst_outputs", {26'd0, bus.parity_bit, bus.parity_valid, bus.parity_err,
                              bus.sticky_err, bus.frame_done, bus.busy}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // 1: TX even, 0xA7, ack held off for 5 cycles.
        sb.push_back('{pv: 1'b1, pb: 1'b1, err: 1'b0});
        start_frame(3'd1, 1'b0, 4'd8);
        check("t1_busy", 32'(bus.busy), 32'd1);
        send_data(8'hA7, 8);
        check("t1_pv", 32'(bus.parity_valid), 32'd1);
        check("t1_pb", 32'(bus.parity_bit), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_hold", {30'd0, bus.parity_valid, bus.parity_bit}, 32'd3);
        end
        do_ack();
        check("t1_done", {29'd0, bus.frame_done, bus.parity_valid, bus.busy}, 32'd4);
        step();
        check("t1_done_pulse", 32'(bus.frame_done), 32'd0);

        // 2: RX odd, 0x41 over 7 bits; wrong then right parity.
        rx_frame(3'd2, 4'd7, 8'h41, 1'b0, 1'b0);
        check("t2_sticky", 32'(bus.sticky_err), 32'd1);
        step();
        check("t2_err_pulse", {30'd0, bus.parity_err, bus.sticky_err}, 32'd1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("t2_clr", 32'(bus.sticky_err), 32'd0);
        rx_frame(3'd2, 4'd7, 8'h41, 1'b1, 1'b0);
        check("t2_no_sticky", 32'(bus.sticky_err), 32'd0);

        // 3: no parity, 5 bits; extra bit afterwards ignored.
        sb.push_back('{pv: 1'b0, pb: 1'b0, err: 1'b0});
        start_frame(3'd0, 1'b0, 4'd5);
        send_data(8'h13, 4);
        check("t3_early", {30'd0, bus.frame_done, bus.busy}, 32'd1);
        send_bit(1'b0);
        check("t3_done", {29'd0, bus.frame_done, bus.parity_valid, bus.busy}, 32'd4);
        send_bit(1'b1);
        check("t3_extra", {30'd0, bus.frame_done, bus.busy}, 32'd0);

        // 4: mark, space, reserved mode, oversize length.
        tx_frame(3'd3, 4'd8, 8'h00);
        tx_frame(3'd4, 4'd8, 8'hFF);
        tx_frame(3'd7, 4'd8, 8'h5A);
        tx_frame(3'd2, 4'd12, 8'hC3);

        // 5: restart mid-frame (with a coincident bit), then reset in PARITY.
        start_frame(3'd1, 1'b0, 4'd8);
        send_data(8'h07, 3);
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        start_frame(3'd1, 1'b0, 4'd8);
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        check("t5_restart", {30'd0, bus.parity_valid, bus.busy}, 32'd1);
        send_data(8'h01, 8);
        check("t5_pv", 32'(bus.parity_valid), 32'd1);
        check("t5_pb", 32'(bus.parity_bit), 32'(par_model(3'd1, 8'h01, 8)));
        rst_n = 1'b0;
        #1;
        check("t5_rst", {26'd0, bus.parity_bit, bus.parity_valid, bus.parity_err,
                         bus.sticky_err, bus.frame_done, bus.busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 6: data_len 0 means 8 bits.
        sb.push_back('{pv: 1'b1, pb: 1'b1, err: 1'b0});
        start_frame(3'd1, 1'b0, 4'd0);
        send_data(8'h01, 7);
        check("t6_len0_mid", {30'd0, bus.parity_valid, bus.busy}, 32'd1);
        send_bit(1'b0);
        check("t6_len0_pv", {30'd0, bus.parity_valid, bus.parity_bit}, 32'd3);
        do_ack();
        check("t6_len0_done", 32'(bus.frame_done), 32'd1);

`ifdef UART_PARITY_ERR_CNT_EN
        begin
            int exp_cnt;
            exp_cnt = 0;
            bus.err_clr = 1'b1;
            step();
            bus.err_clr = 1'b0;
            for (int i = 0; i < 300; i++) begin
                rx_frame(3'd1, 4'd1, 8'h00, 1'b1, 1'b0);
                if (exp_cnt < 255) exp_cnt++;
            end
            step();
            check("t6_cnt_sat", 32'(bus.err_cnt), 32'(exp_cnt));
        end
`endif

        // Error and clear in the same cycle: set wins.
        rx_frame(3'd1, 4'd1, 8'h00, 1'b1, 1'b1);
        check("t6_sticky_win", 32'(bus.sticky_err), 32'd1);
`ifdef UART_PARITY_ERR_CNT_EN
        check("t6_cnt_clr_err", 32'(bus.err_cnt), 32'd1);
`endif
        step();
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
